// File: rtl/sim_exit_ctrl_pkg.sv
// Shared types and constants for the simulation-exit controller and other
// harness monitors.
package sim_ctrl_pkg;

   typedef enum logic {WAIT_ALL = 1'b0, FIRST_FAIL = 1'b1} exit_policy_e;

   typedef enum logic {RUN = 1'b0, DONE = 1'b1} state_e;

   localparam logic [31:0] TIMEOUT_CODE_DEFAULT = 32'hDEAD_0001;

   // One extra bit so that the all-ones index can mean "watchdog".
   function automatic int src_idx_w(input int n_src);
      return $clog2(n_src) + 1;
   endfunction

endpackage

// File: rtl/sim_exit_ctrl_if.sv
// Exit-report bus between the harts/accelerators and the exit controller.
interface sim_exit_ctrl_if #(
   parameter int N_SRC   = 4,
   parameter int VALUE_W = 32
);
   import sim_ctrl_pkg::*;

   localparam int SRC_IDX_W = src_idx_w(N_SRC);

   // src_valid_i is a level or pulse sampled every cycle; a source counts as
   // reported on the first edge where it is valid and masked in, and no ready
   // exists because the controller always accepts that first report.
   // exit_valid_o is sticky and qualifies exit_value_o/exit_src_o/timeout_o.
   logic [N_SRC-1:0]         src_valid_i;
   logic [N_SRC*VALUE_W-1:0] src_value_i;
   logic [N_SRC-1:0]         src_mask_i;
   logic                     progress_i;
   logic                     exit_valid_o;
   logic [VALUE_W-1:0]       exit_value_o;
   logic [SRC_IDX_W-1:0]     exit_src_o;
   logic [N_SRC-1:0]         done_vec_o;
   logic                     timeout_o;

   modport master (
      output src_valid_i, src_value_i, src_mask_i, progress_i,
      input  exit_valid_o, exit_value_o, exit_src_o, done_vec_o, timeout_o
   );

   modport slave (
      input  src_valid_i, src_value_i, src_mask_i, progress_i,
      output exit_valid_o, exit_value_o, exit_src_o, done_vec_o, timeout_o
   );

endinterface

// File: rtl/sim_exit_ctrl_watchdog.sv
// Progress watchdog: saturating cycle counter cleared by a kick, raising a
// combinational expire strobe on the last allowed cycle. LIMIT = 0 disables it.
module sim_watchdog #(
   parameter int LIMIT = 1_000_000
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic en_i,
   input  logic kick_i,
   output logic expire_o
);

   localparam int CNT_W = (LIMIT > 1) ? $clog2(LIMIT) : 1;
   localparam logic [CNT_W-1:0] LAST = (LIMIT > 0) ? CNT_W'(LIMIT - 1) : '0;

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_cnt <= '0;
      end else if (kick_i) begin
         r_cnt <= '0;
      end else if (en_i && (r_cnt != '1)) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign expire_o = (LIMIT != 0) && en_i && !kick_i && (r_cnt == LAST);

endmodule

// File: rtl/sim_exit_ctrl.sv
// Simulation-exit controller: latches the first exit report of each source,
// applies the completion policy and a progress watchdog, then holds the result.
module sim_exit_ctrl
   import sim_ctrl_pkg::*;
#(
   parameter int                  N_SRC          = 4,
   parameter int                  VALUE_W        = 32,
   parameter int                  EXIT_POLICY    = 0,
   parameter int                  TIMEOUT_CYCLES = 1_000_000,
   parameter logic [VALUE_W-1:0]  TIMEOUT_CODE   = VALUE_W'(TIMEOUT_CODE_DEFAULT)
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   sim_exit_ctrl_if.slave      bus,
   output state_e              dbg_state_o
);

   localparam int SRC_IDX_W       = src_idx_w(N_SRC);
   localparam bit FIRST_FAIL_MODE = (EXIT_POLICY == int'(FIRST_FAIL));

   state_e               r_state;
   logic [N_SRC-1:0]     r_done;
   logic [VALUE_W-1:0]   r_value [N_SRC];
   logic [SRC_IDX_W-1:0] r_last_src;
   logic                 r_exit_valid;
   logic [VALUE_W-1:0]   r_exit_value;
   logic [SRC_IDX_W-1:0] r_exit_src;
   logic                 r_timeout;

   logic [N_SRC-1:0]     w_cap;
   logic [N_SRC-1:0]     w_done_nx;
   logic                 w_all_done;
   logic                 w_fail;
   logic [SRC_IDX_W-1:0] w_fail_idx;
   logic [VALUE_W-1:0]   w_fail_val;
   logic [VALUE_W-1:0]   w_val;
   logic                 w_any_cap;
   logic [SRC_IDX_W-1:0] w_cap_hi;
   logic [SRC_IDX_W-1:0] w_ok_src;
   logic                 w_complete;
   logic                 w_expire;

   sim_watchdog #(.LIMIT(TIMEOUT_CYCLES)) u_wdog (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .en_i     (r_state == RUN),
      .kick_i   (bus.progress_i),
      .expire_o (w_expire)
   );

   // Completion looks at the registered captures merged with this cycle's
   // captures, so exit can be decided on the same edge as the last report.
   always_comb begin
      w_cap      = (r_state == RUN) ? (bus.src_mask_i & bus.src_valid_i & ~r_done) : '0;
      w_done_nx  = r_done | w_cap;
      w_all_done = &(w_done_nx | ~bus.src_mask_i);
      w_any_cap  = |w_cap;
      w_fail     = 1'b0;
      w_fail_idx = '0;
      w_fail_val = '0;
      w_val      = '0;
      w_cap_hi   = '0;
      for (int i = N_SRC - 1; i >= 0; i--) begin
         w_val = w_cap[i] ? bus.src_value_i[i*VALUE_W +: VALUE_W] : r_value[i];
         if (w_done_nx[i] && bus.src_mask_i[i] && (w_val != '0)) begin
            w_fail     = 1'b1;
            w_fail_idx = SRC_IDX_W'(i);
            w_fail_val = w_val;
         end
      end
      for (int i = 0; i < N_SRC; i++) begin
         if (w_cap[i]) w_cap_hi = SRC_IDX_W'(i);
      end
      w_ok_src   = w_any_cap ? w_cap_hi : r_last_src;
      w_complete = FIRST_FAIL_MODE ? (w_fail || w_all_done) : w_all_done;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state      <= RUN;
         r_done       <= '0;
         r_last_src   <= '0;
         r_exit_valid <= 1'b0;
         r_exit_value <= '0;
         r_exit_src   <= '0;
         r_timeout    <= 1'b0;
         for (int i = 0; i < N_SRC; i++) r_value[i] <= '0;
      end else if (r_state == RUN) begin
         r_done <= w_done_nx;
         for (int i = 0; i < N_SRC; i++) begin
            if (w_cap[i]) r_value[i] <= bus.src_value_i[i*VALUE_W +: VALUE_W];
         end
         if (w_any_cap) r_last_src <= w_cap_hi;
         // Completion has priority over a watchdog expiry in the same cycle.
         if (w_complete) begin
            r_state      <= DONE;
            r_exit_valid <= 1'b1;
            r_exit_value <= w_fail ? w_fail_val : '0;
            r_exit_src   <= w_fail ? w_fail_idx : w_ok_src;
         end else if (w_expire) begin
            r_state      <= DONE;
            r_exit_valid <= 1'b1;
            r_timeout    <= 1'b1;
            r_exit_value <= TIMEOUT_CODE;
            r_exit_src   <= '1;
         end
      end
   end

   assign bus.exit_valid_o = r_exit_valid;
   assign bus.exit_value_o = r_exit_value;
   assign bus.exit_src_o   = r_exit_src;
   assign bus.done_vec_o   = r_done;
   assign bus.timeout_o    = r_timeout;
   assign dbg_state_o      = r_state;

endmodule

// File: doc/sim_exit_ctrl.md
Name: sim_exit_ctrl

Overview:
- Parametrised simulation-exit controller for the x-alp testharness; generalises the single exit_valid/exit_value pair to N harts/sources.
- Latches per-source exit reports and applies a selectable completion policy.
- Adds a progress watchdog with timeout code.
- Drives the harness-level exit_valid_o/exit_value_o consumed by the simulator top.

Parameters:
- N_SRC, 4, number of exit sources (harts/accelerators), 1..32
- VALUE_W, 32, width of each exit value
- EXIT_POLICY, 0, 0 = wait for all sources; 1 = exit on first non-zero value or when all done
- TIMEOUT_CYCLES, 1_000_000, watchdog limit in clk_i cycles; 0 disables the watchdog
- TIMEOUT_CODE, 32'hDEAD_0001, exit value reported on watchdog expiry

Ports:
- clk_i  in  1  system clock
- rst_ni  in  1  asynchronous active-low reset
- src_valid_i  in  N_SRC  per-source exit strobe; level or pulse, sampled each cycle
- src_value_i  in  N_SRC*VALUE_W  per-source exit value; slice i belongs to source i
- src_mask_i  in  N_SRC  1 = source participates; quasi-static
- progress_i  in  1  watchdog kick, e.g. UART activity or retired-instruction pulse
- exit_valid_o  out  1  sticky, simulation finished
- exit_value_o  out  VALUE_W  final exit code
- exit_src_o  out  $clog2(N_SRC)+1  index of the deciding source; all-ones = watchdog
- done_vec_o  out  N_SRC  per-source captured flags
- timeout_o  out  1  sticky, watchdog expired

Behaviour:
- Clocking and reset
  - One clock, clk_i. Reset is asynchronous and active-low on rst_ni.
  - Reset values: all outputs 0, state RUN, watchdog counter 0, capture registers 0.
- States
  - RUN: collecting reports.
  - DONE: terminal.
  - Only reset leaves DONE. A reset mid-run clears all captures and the counter.
- Capture (RUN only)
  - For each i with src_mask_i[i] & src_valid_i[i] & !done[i]: set done[i] and latch value[i] on that edge.
  - Only the first report is kept. Later strobes from the same source are ignored.
  - Masked-off sources never capture and count as done for completion.
- Completion, evaluated combinationally from the post-capture view (registers plus the current cycle's captures)
  - all_done = &(done | ~src_mask_i).
  - fail = any captured, masked-in value != 0.
  - Policy 0: go to DONE when all_done.
  - Policy 1: go to DONE when fail or all_done.
- Result selection, registered in the same edge that enters DONE
  - If fail: exit_value_o = lowest-index non-zero captured value; exit_src_o = that index.
  - Else: exit_value_o = 0; exit_src_o = highest index captured last. If several sources capture in the final cycle, take the highest of them.
- Timing
  - exit_valid_o rises one cycle after the strobe edge that completes the condition (registered output).
- Watchdog, active only when TIMEOUT_CYCLES != 0
  - Counter increments each RUN cycle and clears on progress_i.
  - Saturates; never wraps.
  - When the counter equals TIMEOUT_CYCLES-1 with no progress_i: go to DONE with timeout_o=1, exit_value_o=TIMEOUT_CODE, exit_src_o=all-ones.
- Simultaneous events
  - Completion and watchdog expiry in the same cycle: completion wins; timeout_o stays 0.
  - progress_i in the expiry cycle prevents expiry.
- Degenerate mask
  - src_mask_i all zero: all_done is true immediately, so DONE on the first cycle after reset with value 0. This is a legal configuration for smoke runs.
- Outputs are stable in DONE. Inputs are ignored in DONE.

Decomposition:
- Shared package sim_ctrl_pkg holds:
  - exit_policy_e enum (WAIT_ALL, FIRST_FAIL)
  - state_e (RUN, DONE)
  - TIMEOUT_CODE default
  - localparam SRC_IDX_W function
- One natural sub-module: sim_watchdog (saturating counter, kick, expire pulse), reusable by other harness monitors.
- Priority selection stays inline as a for-loop.

Test Plan (N_SRC=4, policy 0 unless stated):
- Sources 0..3 report 0 on cycles 10, 12, 12, 20 -> exit_valid_o=1 at cycle 21, value 0, exit_src_o=3, done_vec_o=4'hF.
- Policy 1: src2 reports 32'h5 at cycle 8; others silent -> exit_valid_o at cycle 9, value 5, exit_src_o=2.
- Policy 0: src1 reports 7 and src3 reports 9 in the same cycle, then src0 and src2 report 0 -> exit_value_o=7, exit_src_o=1.
- TIMEOUT_CYCLES=100, no reports, progress_i pulsed at cycle 50 -> timeout_o=1 and exit_value_o=DEAD_0001 at cycle 150, exit_src_o=all-ones.
- src_mask_i=4'b0101: src0 and src2 report 0, src1 toggles valid with value 3 -> completion with value 0; src1 is never captured.
- rst_ni asserted asynchronously mid-run after src0 captured, released, then all four report 0 -> done_vec_o cleared by the reset, completion after the post-reset reports only.
